// File: rtl/board_update_engine.sv
// board_update_engine: resolves one Pac-Man move against the Board RAM,
// redraws the old/new tiles and keeps score and pellet bookkeeping.
module board_update_engine #(
    parameter int RD_LATENCY   = 2,
    parameter int PELLET_TOTAL = 240,
    parameter int PELLET_PTS   = 10,
    parameter int POWER_PTS    = 50
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       game_clear,
    input  logic       move_valid,
    output logic       move_ready,
    input  logic [9:0] cur_addr,
    input  logic [9:0] nxt_addr,
    output logic [9:0] ram_rdaddr,
    input  logic [3:0] ram_q,
    output logic [9:0] ram_wraddr,
    output logic [3:0] ram_wdata,
    output logic       ram_wren,
    output logic [9:0] pac_loc,
    output logic       move_done,
    output logic       move_blocked,
    output logic       power_pulse,
    output logic [15:0] score,
    output logic [8:0] pellets_left,
    output logic       board_cleared
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_READ,
        S_CHECK,
        S_CLEAR_OLD,
        S_DRAW_NEW,
        S_DONE,
        S_BLOCK
    } state_t;

    localparam logic [1:0]  LP_RD_LAST = 2'(RD_LATENCY - 1);
    localparam logic [8:0]  LP_PELLETS = 9'(PELLET_TOTAL);
    localparam logic [9:0]  LP_HOME    = 10'd495;
    localparam logic [3:0]  T_WALL     = 4'd1;
    localparam logic [3:0]  T_PELLET   = 4'd2;
    localparam logic [3:0]  T_PAC      = 4'd3;
    localparam logic [3:0]  T_POWER    = 4'd4;

    state_t      r_state;
    logic [1:0]  r_cnt;
    logic [9:0]  r_cur;
    logic [9:0]  r_nxt;
    logic [3:0]  r_tile;
    logic [9:0]  r_pac_loc;
    logic [15:0] r_score;
    logic [8:0]  r_pellets;
    logic        r_cleared;

    logic [16:0] w_pts;
    logic [16:0] w_sum;
    logic [15:0] w_score_nxt;
    logic        w_eat;
    logic        w_block;

    // Points for the tile sampled in CHECK; anything unknown scores nothing.
    always_comb begin
        w_pts = 17'd0;
        unique case (1'b1)
            (r_tile == T_PELLET): w_pts = 17'(PELLET_PTS);
            (r_tile == T_POWER):  w_pts = 17'(POWER_PTS);
            default:              w_pts = 17'd0;
        endcase
    end

    assign w_sum       = {1'b0, r_score} + w_pts;
    assign w_score_nxt = w_sum[16] ? 16'hFFFF : w_sum[15:0];
    assign w_eat       = (r_tile == T_PELLET) || (r_tile == T_POWER);
    assign w_block     = (r_nxt > 10'd767) || (ram_q == T_WALL) ||
                         (r_nxt == r_cur);

    // Move sequencer plus score / pellet / position bookkeeping.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state   <= S_IDLE;
            r_cnt     <= 2'd0;
            r_cur     <= 10'd0;
            r_nxt     <= 10'd0;
            r_tile    <= 4'd0;
            r_pac_loc <= LP_HOME;
            r_score   <= 16'd0;
            r_pellets <= LP_PELLETS;
            r_cleared <= 1'b0;
        end else begin
            r_cleared <= (r_pellets == 9'd0);
            if (game_clear) begin
                r_state   <= S_IDLE;
                r_pac_loc <= LP_HOME;
                r_score   <= 16'd0;
                r_pellets <= LP_PELLETS;
            end else begin
                unique case (r_state)
                    S_IDLE: begin
                        if (move_valid) begin
                            r_cur   <= cur_addr;
                            r_nxt   <= nxt_addr;
                            r_cnt   <= 2'd0;
                            r_state <= S_READ;
                        end
                    end
                    S_READ: begin
                        if (r_cnt == LP_RD_LAST) r_state <= S_CHECK;
                        else                     r_cnt   <= r_cnt + 2'd1;
                    end
                    S_CHECK: begin
                        r_tile  <= ram_q;
                        r_state <= w_block ? S_BLOCK : S_CLEAR_OLD;
                    end
                    S_CLEAR_OLD: r_state <= S_DRAW_NEW;
                    S_DRAW_NEW: begin
                        r_state   <= S_DONE;
                        r_pac_loc <= r_nxt;
                        r_score   <= w_score_nxt;
                        if (w_eat && (r_pellets != 9'd0))
                            r_pellets <= r_pellets - 9'd1;
                    end
                    S_DONE:  r_state <= S_IDLE;
                    S_BLOCK: r_state <= S_IDLE;
                    default: r_state <= S_IDLE;
                endcase
            end
        end
    end

    // Moore decodes; a clear kills writes and pulses in its own cycle.
    assign move_ready    = (r_state == S_IDLE);
    assign ram_rdaddr    = r_nxt;
    assign ram_wren      = ((r_state == S_CLEAR_OLD) ||
                            (r_state == S_DRAW_NEW)) && !game_clear;
    assign ram_wraddr    = (r_state == S_DRAW_NEW) ? r_nxt : r_cur;
    assign ram_wdata     = (r_state == S_DRAW_NEW) ? T_PAC : 4'd0;
    assign move_done     = (r_state == S_DONE) && !game_clear;
    assign move_blocked  = (r_state == S_BLOCK) && !game_clear;
    assign power_pulse   = (r_state == S_DONE) && (r_tile == T_POWER) &&
                           !game_clear;
    assign pac_loc       = r_pac_loc;
    assign score         = r_score;
    assign pellets_left  = r_pellets;
    assign board_cleared = r_cleared;

endmodule

// File: tb/tb_board_update_engine.sv
// tb_board_update_engine: directed moves against a small Board RAM
// model with a two-cycle read pipeline.
module tb_board_update_engine;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        game_clear = 1'b0;
    logic        move_valid = 1'b0;
    logic        move_ready;
    logic [9:0]  cur_addr = 10'd0;
    logic [9:0]  nxt_addr = 10'd0;
    logic [9:0]  ram_rdaddr;
    logic [3:0]  ram_q;
    logic [9:0]  ram_wraddr;
    logic [3:0]  ram_wdata;
    logic        ram_wren;
    logic [9:0]  pac_loc;
    logic        move_done;
    logic        move_blocked;
    logic        power_pulse;
    logic [15:0] score;
    logic [8:0]  pellets_left;
    logic        board_cleared;

    board_update_engine dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .game_clear   (game_clear),
        .move_valid   (move_valid),
        .move_ready   (move_ready),
        .cur_addr     (cur_addr),
        .nxt_addr     (nxt_addr),
        .ram_rdaddr   (ram_rdaddr),
        .ram_q        (ram_q),
        .ram_wraddr   (ram_wraddr),
        .ram_wdata    (ram_wdata),
        .ram_wren     (ram_wren),
        .pac_loc      (pac_loc),
        .move_done    (move_done),
        .move_blocked (move_blocked),
        .power_pulse  (power_pulse),
        .score        (score),
        .pellets_left (pellets_left),
        .board_cleared(board_cleared)
    );

    always #5 clk = ~clk;

    logic [3:0] mem [0:1023];
    logic [3:0] p1, p2;

    // Board RAM read path, latency 2
    always @(posedge clk) begin
        p1 <= mem[ram_rdaddr];
        p2 <= p1;
    end
    assign ram_q = p2;

    int n_checks = 0;
    int n_fail = 0;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    int         done_c, blk_c, rdy_c, nw, w0c, w1c;
    logic [9:0] w0a, w1a, rd1, loc_d;
    logic [3:0] w0d, w1d;
    logic       pulse_d, clr_d, clr_a;
    logic [15:0] score_d;
    logic [8:0] pel_d;

    task automatic wait_ready();
        int i;
        for (i = 0; i < 20 && !move_ready; i++) @(negedge clk);
        if (!move_ready) check("ready_timeout", 0, 1);
    endtask

    // Issue one move and log what happens in cycles 1..12.
    task automatic run_move(input logic [9:0] c, input logic [9:0] n,
                            input logic [3:0] t);
        mem[n] = t;
        wait_ready();
        move_valid = 1'b1;
        cur_addr   = c;
        nxt_addr   = n;
        done_c = -1; blk_c = -1; rdy_c = -1; nw = 0; w0c = -1; w1c = -1;
        w0a = '0; w1a = '0; w0d = '0; w1d = '0; rd1 = '0; loc_d = '0;
        pulse_d = 1'b0; clr_d = 1'b0; clr_a = 1'b0;
        score_d = '0; pel_d = '0;
        for (int cyc = 1; cyc <= 12; cyc++) begin
            @(negedge clk);
            if (cyc == 1) begin
                move_valid = 1'b0;
                rd1 = ram_rdaddr;
            end
            if (ram_wren) begin
                if (nw == 0) begin
                    w0a = ram_wraddr; w0d = ram_wdata; w0c = cyc;
                end else if (nw == 1) begin
                    w1a = ram_wraddr; w1d = ram_wdata; w1c = cyc;
                end
                nw++;
            end
            if (move_done && done_c < 0) begin
                done_c  = cyc;
                pulse_d = power_pulse;
                score_d = score;
                pel_d   = pellets_left;
                loc_d   = pac_loc;
                clr_d   = board_cleared;
            end
            if (done_c > 0 && cyc == done_c + 1) clr_a = board_cleared;
            if (move_blocked && blk_c < 0) blk_c = cyc;
            if (move_ready && rdy_c < 0) rdy_c = cyc;
        end
    endtask

    int         bad;
    int         exp_score, exp_pel;
    logic [9:0] loc, nx;
    logic       any_wr, any_evt;

    initial begin
        for (int i = 0; i < 1024; i++) mem[i] = 4'd0;

        repeat (3) @(negedge clk);
        reset_n = 1'b1;
        #1;
        check("rst_ready", move_ready, 1);
        check("rst_loc", pac_loc, 495);
        check("rst_score", score, 0);
        check("rst_pellets", pellets_left, 240);
        check("rst_cleared", board_cleared, 0);
        check("rst_rdaddr", ram_rdaddr, 0);
        any_wr = 1'b0;
        any_evt = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            any_wr |= ram_wren;
            any_evt |= move_done | move_blocked | power_pulse | ~move_ready;
        end
        check("rst_idle_wren", any_wr, 0);
        check("rst_idle_evt", any_evt, 0);

        // pellet move 495 -> 496
        run_move(10'd495, 10'd496, 4'd2);
        check("pel_rdaddr", rd1, 496);
        check("pel_nwrites", nw, 2);
        check("pel_w0_cyc", w0c, 4);
        check("pel_w0_addr", w0a, 495);
        check("pel_w0_data", w0d, 0);
        check("pel_w1_cyc", w1c, 5);
        check("pel_w1_addr", w1a, 496);
        check("pel_w1_data", w1d, 3);
        check("pel_done_cyc", done_c, 6);
        check("pel_pulse", pulse_d, 0);
        check("pel_score", score_d, 10);
        check("pel_pellets", pel_d, 239);
        check("pel_loc", loc_d, 496);
        check("pel_ready_cyc", rdy_c, 7);
        check("pel_blocked", blk_c, -1);

        // wall at 497
        run_move(10'd496, 10'd497, 4'd1);
        check("wall_blk_cyc", blk_c, 4);
        check("wall_nwrites", nw, 0);
        check("wall_done", done_c, -1);
        check("wall_ready_cyc", rdy_c, 5);
        check("wall_score", score, 10);
        check("wall_loc", pac_loc, 496);
        check("wall_pellets", pellets_left, 239);

        // off-board address
        run_move(10'd496, 10'd768, 4'd2);
        check("oob_blk_cyc", blk_c, 4);
        check("oob_nwrites", nw, 0);
        check("oob_score", score, 10);

        // stay in place
        run_move(10'd496, 10'd496, 4'd2);
        check("same_blk_cyc", blk_c, 4);
        check("same_nwrites", nw, 0);
        check("same_loc", pac_loc, 496);

        // power pellets: exhaust board, then drive score to saturation
        exp_score = 10;
        exp_pel = 239;
        loc = 10'd496;
        bad = 0;
        for (int k = 1; k <= 1311; k++) begin
            nx = (loc == 10'd495) ? 10'd496 : 10'd495;
            run_move(loc, nx, 4'd4);
            exp_score = (exp_score + 50 > 65535) ? 65535 : exp_score + 50;
            if (exp_pel > 0) exp_pel--;
            if (done_c != 6 || pulse_d !== 1'b1 || nw != 2 ||
                score_d != 16'(exp_score) || pel_d != 9'(exp_pel) ||
                loc_d != nx)
                bad++;
            loc = nx;
            if (k == 239) begin
                check("last_pellet_left", pel_d, 0);
                check("cleared_at_done", clr_d, 0);
                check("cleared_after_done", clr_a, 1);
            end
            if (k == 1310) check("score_pre_sat", score_d, 65510);
            if (k == 1311) begin
                check("score_sat", score_d, 16'hFFFF);
                check("power_pulse_at_done", pulse_d, 1);
                check("power_done_cyc", done_c, 6);
            end
        end
        check("power_loop_bad", bad, 0);
        check("pellets_floor", pellets_left, 0);
        check("board_cleared_hold", board_cleared, 1);

        // game_clear while clearing the old tile
        mem[496] = 4'd2;
        wait_ready();
        move_valid = 1'b1;
        cur_addr = 10'd495;
        nxt_addr = 10'd496;
        @(negedge clk);
        move_valid = 1'b0;
        for (int i = 0; i < 12 && !ram_wren; i++) @(negedge clk);
        check("gc_clear_old_addr", ram_wraddr, 495);
        check("gc_clear_old_wren", ram_wren, 1);
        game_clear = 1'b1;
        move_valid = 1'b1;
        #1;
        check("gc_wren_forced", ram_wren, 0);
        @(negedge clk);
        check("gc_ready", move_ready, 1);
        check("gc_score", score, 0);
        check("gc_loc", pac_loc, 495);
        check("gc_pellets", pellets_left, 240);
        any_wr = 1'b0;
        any_evt = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            any_wr |= ram_wren;
            any_evt |= move_done | move_blocked | ~move_ready;
        end
        move_valid = 1'b0;
        game_clear = 1'b0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            any_wr |= ram_wren;
            any_evt |= move_done | move_blocked | ~move_ready;
        end
        check("gc_no_write", any_wr, 0);
        check("gc_no_event", any_evt, 0);
        check("gc_cleared_low", board_cleared, 0);

        // a normal move after the clear
        run_move(10'd495, 10'd496, 4'd2);
        check("post_gc_score", score_d, 10);
        check("post_gc_pellets", pel_d, 239);

        // reset during READ
        mem[495] = 4'd2;
        wait_ready();
        move_valid = 1'b1;
        cur_addr = 10'd496;
        nxt_addr = 10'd495;
        @(negedge clk);
        move_valid = 1'b0;
        check("rr_busy", move_ready, 0);
        reset_n = 1'b0;
        #1;
        check("rr_ready", move_ready, 1);
        check("rr_score", score, 0);
        check("rr_loc", pac_loc, 495);
        check("rr_pellets", pellets_left, 240);
        check("rr_rdaddr", ram_rdaddr, 0);
        any_wr = ram_wren;
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        any_evt = 1'b0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            any_wr |= ram_wren;
            any_evt |= move_done | move_blocked | ~move_ready;
        end
        check("rr_no_write", any_wr, 0);
        check("rr_no_event", any_evt, 0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/board_update_engine.md
Name: board_update_engine

Overview:
- Downstream of the Pac-Man movement logic. Accepts one move request at a time, giving the current and next block addresses on the 32x24 board.
- Reads the tile at the next block to resolve walls, pellets and power pellets, then clears the old tile and draws Pac-Man at the new one through the Board RAM write port.
- Maintains the score and the remaining-pellet count that the HEX/game-end logic consumes.
- Replaces ad-hoc clear/draw sequencing in the top level.

Parameters:
- RD_LATENCY, 2, Board RAM read latency in clk cycles from ram_rdaddr to valid ram_q (range 1..3).
- PELLET_TOTAL, 240, pellet plus power-pellet count on a fresh board; reload value of pellets_left.
- PELLET_PTS, 10, score added for eating a pellet.
- POWER_PTS, 50, score added for eating a power pellet.

Ports:
- clk  in  1  system clock (CLOCK_50 domain).
- reset_n  in  1  asynchronous, active-low reset.
- game_clear  in  1  synchronous level; restarts the game state (driven from start).
- move_valid  in  1  move request valid.
- move_ready  out  1  engine idle; a request is accepted when move_valid && move_ready at a posedge.
- cur_addr  in  10  current Pac-Man block address (block_y*32+block_x).
- nxt_addr  in  10  requested block address.
- ram_rdaddr  out  10  Board RAM read address.
- ram_q  in  4  Board RAM read data.
- ram_wraddr  out  10  Board RAM write address.
- ram_wdata  out  4  Board RAM write data.
- ram_wren  out  1  Board RAM write enable.
- pac_loc  out  10  committed Pac-Man block address.
- move_done  out  1  1-cycle pulse: the move has been committed.
- move_blocked  out  1  1-cycle pulse: the move was rejected.
- power_pulse  out  1  1-cycle pulse, coincident with move_done, when a power pellet is eaten.
- score  out  16  accumulated score, saturating.
- pellets_left  out  9  remaining pellets.
- board_cleared  out  1  level high while pellets_left == 0.

Behaviour:
- Tile codes: 0 empty, 1 wall, 2 pellet, 3 Pac-Man, 4 power pellet. Any other code is treated as empty.
- Reset (reset_n low, asynchronous):
  - state IDLE, move_ready 1, pac_loc 495.
  - score 0, pellets_left PELLET_TOTAL, board_cleared 0.
  - all pulses 0, ram_wren 0, ram_rdaddr 0.
  - Reset mid-move abandons the move with no further writes.
- States: IDLE, READ, CHECK, CLEAR_OLD, DRAW_NEW, DONE, BLOCK.
- IDLE:
  - move_ready = 1 only in IDLE.
  - On accept: latch cur/nxt into internal registers, go to READ.
  - The request inputs are ignored while busy.
- READ:
  - ram_rdaddr = latched nxt throughout READ, and is held there until the next accept.
  - Stays in READ for RD_LATENCY cycles (counter), then goes to CHECK.
- CHECK: samples ram_q.
  - Go to BLOCK if latched nxt > 767, or ram_q == 1, or nxt == cur.
  - Otherwise go to CLEAR_OLD.
- CLEAR_OLD: ram_wren=1, ram_wraddr=cur, ram_wdata=0.
- DRAW_NEW: ram_wren=1, ram_wraddr=nxt, ram_wdata=3.
- DONE (one cycle, then IDLE):
  - move_done=1; power_pulse=1 if the sampled tile was 4.
  - pac_loc, score and pellets_left update on the edge entering DONE.
- BLOCK (one cycle, then IDLE): move_blocked=1; no writes; pac_loc, score and pellets_left unchanged.
- Write outputs and pulses are Moore decodes of the state register. ram_wren is 0 in all other states.
- Latency, counting the accept cycle as cycle 0:
  - move_done high in cycle RD_LATENCY+4.
  - move_blocked high in cycle RD_LATENCY+2.
  - Next accept possible in cycle RD_LATENCY+5 (committed move) or RD_LATENCY+3 (blocked move).
- Score arithmetic:
  - pellet: score += PELLET_PTS; power pellet: score += POWER_PTS.
  - 17-bit sum, saturating at 16'hFFFF.
- pellets_left:
  - decrements by 1 on each pellet or power pellet eaten; never decrements below 0.
  - board_cleared = (pellets_left == 0), registered.
- game_clear (synchronous, has priority over every state transition):
  - next state IDLE; ram_wren forced 0 that cycle.
  - score 0, pellets_left PELLET_TOTAL, pac_loc 495, pulses 0.
  - Held high, the engine stays in IDLE and accepts nothing.
- Simultaneous game_clear and move_valid in IDLE: game_clear wins; the request is not accepted.

Test Plan:
- Reset then idle: after reset_n release -> move_ready=1, pac_loc=495, score=0, pellets_left=240, ram_wren=0 for 10 cycles.
- Pellet move: cur=495, nxt=496, tile 2 (RD_LATENCY=2) -> cycle 4 writes (495,0), cycle 5 writes (496,3), cycle 6 move_done=1, score=10, pellets_left=239, pac_loc=496.
- Wall move: nxt=497, tile 1 -> move_blocked in cycle 4, no ram_wren, score/pac_loc unchanged, move_ready=1 in cycle 5.
- Power pellet with saturation: preload score near 16'hFFF0 by repeated moves (or force), tile 4 -> power_pulse coincident with move_done, score=16'hFFFF.
- Boundaries: nxt=768 -> blocked; nxt==cur -> blocked; eating the last pellet -> pellets_left=0, board_cleared=1 the cycle after DONE.
- Aborts: game_clear asserted during CLEAR_OLD -> no DRAW_NEW write, IDLE next cycle, score=0, pac_loc=495; reset_n low during READ -> immediate reset values, no writes.
